// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze with timeout, taken-branch flush,
// load-use bubble insertion, and a saturating stall-cycle counter.
module hazard_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Instruction_id,
    input  logic        MemRead_ex,
    input  logic [4:0]  rt_ex,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFFlush,
    output logic        IDFlush,
    output logic        pipe_hold,
    output logic        mem_timeout,
    output logic        mem_err,
    output logic [15:0] stall_cycles
);

    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] MEMWAIT = 1'b1;

    logic [0:0] state;
    logic [3:0] wait_cnt;

    logic [5:0] opcode;
    logic [4:0] rs_id;
    logic [4:0] rt_id;
    logic       uses_rt;
    logic       load_use;
    logic       at_limit;
    logic       pending;
    logic       freeze;
    logic       timeout;

    assign opcode  = Instruction_id[31:26];
    assign rs_id   = Instruction_id[25:21];
    assign rt_id   = Instruction_id[20:16];

    // R-type, sw, beq, bne read rt as a source; everything else writes or ignores it.
    assign uses_rt = (opcode == 6'h00) || (opcode == 6'h2B) ||
                     (opcode == 6'h04) || (opcode == 6'h05);

    assign load_use = MemRead_ex && (rt_ex != 5'd0) &&
                      ((rt_ex == rs_id) || (uses_rt && (rt_ex == rt_id)));

    assign pending  = mem_req && !mem_ready;
    assign at_limit = (state == MEMWAIT) && (wait_cnt == 4'd15);
    assign freeze   = pending && !at_limit;
    assign timeout  = pending && at_limit;

    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IFFlush     = 1'b0;
        IDFlush     = 1'b0;
        pipe_hold   = 1'b0;
        mem_timeout = 1'b0;
        if (!reset) begin
            mem_timeout = timeout;
            if (freeze) begin
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                pipe_hold = 1'b1;
            end else if (branch_taken) begin
                IFFlush = 1'b1;
                IDFlush = 1'b1;
            end else if (load_use) begin
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                IDFlush   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= 4'd0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (pending) begin
                        state    <= MEMWAIT;
                        wait_cnt <= 4'd1;
                    end
                end
                default: begin
                    // Abandoning a wait drops back to RUN; a lingering request re-enters next cycle.
                    if (!pending || timeout) begin
                        state    <= RUN;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
            endcase
            if (timeout)
                mem_err <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            stall_cycles <= 16'd0;
        else if (!PCWrite && (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs change on the falling edge, outputs are
// checked 1ns later against hand-computed values.
module tb_hazard_ctrl;

    logic        clock;
    logic        reset;
    logic [31:0] Instruction_id;
    logic        MemRead_ex;
    logic [4:0]  rt_ex;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IFFlush;
    logic        IDFlush;
    logic        pipe_hold;
    logic        mem_timeout;
    logic        mem_err;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    hazard_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .Instruction_id (Instruction_id),
        .MemRead_ex     (MemRead_ex),
        .rt_ex          (rt_ex),
        .branch_taken   (branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .PCWrite        (PCWrite),
        .IFIDWrite      (IFIDWrite),
        .IFFlush        (IFFlush),
        .IDFlush        (IDFlush),
        .pipe_hold      (pipe_hold),
        .mem_timeout    (mem_timeout),
        .mem_err        (mem_err),
        .stall_cycles   (stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, 16'h0000};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed control outputs {PCWrite, IFIDWrite, IFFlush, IDFlush, pipe_hold}
    function automatic logic [4:0] ctl();
        return {PCWrite, IFIDWrite, IFFlush, IDFlush, pipe_hold};
    endfunction

    task automatic apply(input logic [31:0] ir, input logic mre, input logic [4:0] rte,
                         input logic br, input logic mq, input logic mr);
        @(negedge clock);
        Instruction_id = ir;
        MemRead_ex     = mre;
        rt_ex          = rte;
        branch_taken   = br;
        mem_req        = mq;
        mem_ready      = mr;
        #1;
    endtask

    initial begin
        // Reset with every hazard source active: outputs must still be the pass-through values.
        reset = 1'b1;
        Instruction_id = mk(6'h00, 5'd5, 5'd6);
        MemRead_ex = 1'b1; rt_ex = 5'd5; branch_taken = 1'b1;
        mem_req = 1'b1; mem_ready = 1'b0;
        #12;
        chk("reset_ctl", ctl(), 5'b11000);
        chk("reset_timeout", mem_timeout, 1'b0);
        chk("reset_err", mem_err, 1'b0);
        chk("reset_stall", stall_cycles, 16'd0);

        apply(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        chk("idle_ctl", ctl(), 5'b11000);

        // Load-use on rs of an add
        apply(mk(6'h00, 5'd5, 5'd6), 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("lu_add_ctl", ctl(), 5'b00010);
        apply(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("lu_add_stall", stall_cycles, 16'd1);

        // sw reads rt
        apply(mk(6'h2B, 5'd1, 5'd5), 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("lu_sw_ctl", ctl(), 5'b00010);
        // lw does not read rt
        apply(mk(6'h23, 5'd1, 5'd7), 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        chk("lw_rt_nostall", ctl(), 5'b11000);
        // $zero never creates a hazard
        apply(mk(6'h00, 5'd0, 5'd0), 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("r0_nostall", ctl(), 5'b11000);
        chk("stall_after_sw", stall_cycles, 16'd2);
        // bne reads rt
        apply(mk(6'h05, 5'd3, 5'd9), 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        chk("lu_bne_ctl", ctl(), 5'b00010);

        // Branch wins over load-use
        apply(mk(6'h00, 5'd5, 5'd6), 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("br_lu_ctl", ctl(), 5'b11110);
        apply(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("br_lu_stall", stall_cycles, 16'd3);

        // Memory wait: three frozen cycles (branch pending underneath, must be masked), ready on the 4th
        for (int i = 1; i <= 3; i++) begin
            apply(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
            chk($sformatf("mw_freeze_%0d", i), ctl(), 5'b00001);
        end
        apply(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("mw_ready_ctl", ctl(), 5'b11000);
        apply(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("mw_stall", stall_cycles, 16'd6);
        chk("mw_no_err", mem_err, 1'b0);

        // Timeout: 15 frozen cycles, pulse on the 16th
        for (int i = 1; i <= 15; i++) begin
            apply(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("to_freeze_%0d", i), {ctl(), mem_timeout}, 6'b000010);
        end
        apply(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("to_pulse", {ctl(), mem_timeout}, 6'b110001);
        chk("to_err_pre", mem_err, 1'b0);
        apply(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("to_pulse_gone", mem_timeout, 1'b0);
        chk("to_err_set", mem_err, 1'b1);
        chk("to_stall", stall_cycles, 16'd21);
        apply(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("to_err_sticky", mem_err, 1'b1);

        // Reset in the middle of a wait (wait_cnt=6)
        for (int i = 0; i < 7; i++)
            apply(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("mid_pre_stall", stall_cycles, 16'd27);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_ctl", {ctl(), mem_timeout}, 6'b110000);
        chk("mid_rst_err", mem_err, 1'b0);
        chk("mid_rst_stall", stall_cycles, 16'd0);
        @(posedge clock); #1;
        chk("mid_rst_hold", {ctl(), mem_timeout}, 6'b110000);
        apply(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        // A fresh request after reset must start a full wait from RUN
        apply(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_freeze", {ctl(), mem_timeout}, 6'b000010);
        apply(mk(6'h00, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_stall", stall_cycles, 16'd1);
        chk("post_rst_err", mem_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
